// File: rtl/screen_seq.sv
// PONG screen sequencer: MENU/GAME/OVER/CREDITS FSM switching pipelines on vsync rise.
// Pipeline-to-output latency 1 clk; state changes 2 clks after raw vsync rise; no backpressure.
module screen_seq #(
  parameter int CRED_FRAMES = 600,
  parameter int OVER_FRAMES = 180,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic        game_over,
  input  logic [11:0] menu_rgb,
  input  logic        menu_hsync,
  input  logic        menu_vsync,
  input  logic [11:0] game_rgb,
  input  logic        game_hsync,
  input  logic        game_vsync,
  input  logic [11:0] cred_rgb,
  input  logic        cred_hsync,
  input  logic        cred_vsync,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [1:0]  screen,
  output logic        game_rst,
  output logic        cred_rst,
  output logic        game_freeze
);

  typedef enum logic [1:0] {
    S_MENU = 2'd0,
    S_GAME = 2'd1,
    S_OVER = 2'd2,
    S_CRED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CRED_LAST = CNT_W'(CRED_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             vs_r, vs_d, ml_r, ml_d, mr_r, mr_d;
  logic [1:0]       arm;
  logic             frame, l_rise, r_rise;
  logic             req_l, req_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      ml_r <= 1'b0;
      ml_d <= 1'b0;
      mr_r <= 1'b0;
      mr_d <= 1'b0;
      arm  <= 2'b00;
    end else begin
      vs_r <= vsync_in;
      vs_d <= vs_r;
      ml_r <= mouse_left;
      ml_d <= ml_r;
      mr_r <= mouse_right;
      mr_d <= mr_r;
      arm  <= {arm[0], 1'b1};
    end
  end

  // The _d registers only hold a genuine post-reset sample once arm[1] is set,
  // so a level already high at reset release never reads as a rise.
  assign frame  = vs_r & ~vs_d & arm[1];
  assign l_rise = ml_r & ~ml_d & arm[1];
  assign r_rise = mr_r & ~mr_d & arm[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (frame) begin
      case (state)
        S_MENU: begin
          if (req_l || l_rise) begin
            state_nxt = S_GAME;
          end else if (req_r) begin
            state_nxt = S_CRED;
            cnt_nxt   = '0;
          end
        end
        S_GAME: begin
          if (game_over) begin
            state_nxt = S_OVER;
            cnt_nxt   = '0;
          end
        end
        S_OVER: begin
          if (cnt == OVER_LAST) begin
            state_nxt = S_MENU;
            cnt_nxt   = '0;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_CRED: begin
          if (req_l || cnt == CRED_LAST) begin
            state_nxt = S_MENU;
            cnt_nxt   = '0;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_MENU;
      cnt      <= '0;
      req_l    <= 1'b0;
      req_r    <= 1'b0;
      game_rst <= 1'b0;
      cred_rst <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      game_rst <= (state_nxt == S_GAME) && (state != S_GAME);
      cred_rst <= (state_nxt == S_CRED) && (state != S_CRED);
      // State only moves on a frame, so clearing on frame also covers every state change.
      if (frame) begin
        req_l <= 1'b0;
        req_r <= 1'b0;
      end else begin
        if (l_rise) req_l <= 1'b1;
        if (r_rise) req_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_out   <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      case (state)
        S_MENU: begin
          rgb_out   <= menu_rgb;
          hsync_out <= menu_hsync;
          vsync_out <= menu_vsync;
        end
        S_GAME, S_OVER: begin
          rgb_out   <= game_rgb;
          hsync_out <= game_hsync;
          vsync_out <= game_vsync;
        end
        S_CRED: begin
          rgb_out   <= cred_rgb;
          hsync_out <= cred_hsync;
          vsync_out <= cred_vsync;
        end
      endcase
    end
  end

  assign screen      = state;
  assign game_freeze = (state == S_OVER);

endmodule

// File: tb/tb_screen_seq.sv
// Bench for screen_seq: frame-by-frame vector table plus reset corner sequences.
module tb_screen_seq;

  localparam logic [11:0] MENU_RGB = 12'hABC;
  localparam logic [11:0] GAME_RGB = 12'h123;
  localparam logic [11:0] CRED_RGB = 12'h456;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_in, mouse_left, mouse_right, game_over;
  logic [11:0] menu_rgb, game_rgb, cred_rgb;
  logic        menu_hsync, menu_vsync, game_hsync, game_vsync, cred_hsync, cred_vsync;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out;
  logic [1:0]  screen;
  logic        game_rst, cred_rst, game_freeze;

  always #5 clk = ~clk;

  screen_seq #(.CRED_FRAMES(3), .OVER_FRAMES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in),
    .mouse_left(mouse_left), .mouse_right(mouse_right), .game_over(game_over),
    .menu_rgb(menu_rgb), .menu_hsync(menu_hsync), .menu_vsync(menu_vsync),
    .game_rgb(game_rgb), .game_hsync(game_hsync), .game_vsync(game_vsync),
    .cred_rgb(cred_rgb), .cred_hsync(cred_hsync), .cred_vsync(cred_vsync),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .screen(screen), .game_rst(game_rst), .cred_rst(cred_rst), .game_freeze(game_freeze)
  );

  typedef struct {
    logic       pl;
    logic       pr;
    logic       go;
    logic [1:0] scr;
    logic       grst;
    logic       crst;
    logic       frz;
  } vec_t;

  vec_t       vecs [18];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] cur_scr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] pipe_of(input logic [1:0] s);
    case (s)
      2'd0:    return {MENU_RGB, 1'b1, 1'b0};
      2'd3:    return {CRED_RGB, 1'b1, 1'b1};
      default: return {GAME_RGB, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic drive_pipes();
    menu_rgb = MENU_RGB; menu_hsync = 1'b1; menu_vsync = 1'b0;
    game_rgb = GAME_RGB; game_hsync = 1'b0; game_vsync = 1'b1;
    cred_rgb = CRED_RGB; cred_hsync = 1'b1; cred_vsync = 1'b1;
  endtask

  // One frame: optional mid-frame button pulses, then a vsync rise and the switch window.
  task automatic frame_step(input logic pl, input logic pr, input logic go,
                            input logic [1:0] exp_scr, input logic exp_g, input logic exp_c,
                            input logic exp_f, input string tag);
    int ng;
    int nc;
    @(negedge clk);
    vsync_in  = 1'b0;
    game_over = go;
    repeat (2) @(negedge clk);
    if (pl) mouse_left = 1'b1;
    if (pr) mouse_right = 1'b1;
    repeat (2) @(negedge clk);
    if (pl) mouse_left = 1'b0;
    if (pr) mouse_right = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " screen mid-frame"}, 32'(screen), 32'(cur_scr));
    vsync_in = 1'b1;
    ng = 0;
    nc = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ng += int'(game_rst);
      nc += int'(cred_rst);
      if (i == 1) check({tag, " screen 1 clk after rise"}, 32'(screen), 32'(cur_scr));
      if (i == 2) begin
        check({tag, " screen"}, 32'(screen), 32'(exp_scr));
        check({tag, " game_freeze"}, 32'(game_freeze), 32'(exp_f));
      end
      if (i == 3) check({tag, " output mux"}, 32'({rgb_out, hsync_out, vsync_out}), 32'(pipe_of(exp_scr)));
    end
    check({tag, " game_rst cycles"}, 32'(ng), 32'(exp_g));
    check({tag, " cred_rst cycles"}, 32'(nc), 32'(exp_c));
    cur_scr = exp_scr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //               pl    pr    go    scr    grst  crst  frz
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};

    // Reset with every input toggling.
    rst = 1'b0;
    cur_scr = 2'd0;
    drive_pipes();
    vsync_in = 1'b0; mouse_left = 1'b0; mouse_right = 1'b0; game_over = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vsync_in    = 1'($urandom);
      mouse_left  = 1'($urandom);
      mouse_right = 1'($urandom);
      game_over   = 1'($urandom);
      menu_rgb    = 12'($urandom);
      game_rgb    = 12'($urandom);
      cred_rgb    = 12'($urandom);
      menu_hsync  = 1'($urandom);
      game_vsync  = 1'($urandom);
    end
    #1;
    check("reset outputs", 32'({rgb_out, hsync_out, vsync_out, game_rst, cred_rst, game_freeze}), 32'd0);
    check("reset screen", 32'(screen), 32'd0);

    @(negedge clk);
    drive_pipes();
    vsync_in = 1'b0; mouse_left = 1'b0; mouse_right = 1'b0; game_over = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("menu rgb after release", 32'(rgb_out), 32'h0ABC);
    menu_rgb = 12'h5A5;
    @(negedge clk);
    check("menu rgb latency", 32'(rgb_out), 32'h05A5);
    menu_rgb = MENU_RGB;

    for (int v = 0; v < 18; v++) begin
      frame_step(vecs[v].pl, vecs[v].pr, vecs[v].go, vecs[v].scr,
                 vecs[v].grst, vecs[v].crst, vecs[v].frz, $sformatf("vec%0d", v));
    end

    // Reset in frame 1 of CREDITS with a pending left request and a held button.
    @(negedge clk);
    vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    mouse_left = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("async reset screen", 32'(screen), 32'd0);
    check("async reset outputs", 32'({rgb_out, hsync_out, vsync_out, game_freeze}), 32'd0);
    cur_scr = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      frame_step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, $sformatf("post-reset held%0d", k));
    end
    mouse_left = 1'b0;
    frame_step(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, "post-reset start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/screen_seq.md
# screen_seq

Top-level screen sequencer for PONG. It owns the state machine MENU → GAME → OVER → MENU, plus the MENU ↔ CREDITS path. It selects which drawing pipeline (menu, game, credits) drives the VGA outputs, and it issues restart pulses to the game and credits pipelines. All screen changes are aligned to the frame boundary (rising edge of `vsync_in`), so no frame is ever split between two pipelines.

## Interface
Parameters:
- `CRED_FRAMES`, default 600: frames the credits screen stays up before it returns to MENU automatically (10 s at 60 Hz).
- `OVER_FRAMES`, default 180: frames the frozen game-over picture is held.
- `CNT_W`, default 16: width of the frame counter. Must satisfy `CRED_FRAMES`, `OVER_FRAMES` < 2^`CNT_W`.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-low.
- `vsync_in` in 1: vsync from the timing generator; its rising edge is the frame boundary.
- `mouse_left` in 1: level input from the mouse block.
- `mouse_right` in 1: level input from the mouse block.
- `game_over` in 1: level input from the game logic; it is sampled only while in GAME.
- `menu_rgb` in 12: menu pipeline colour.
- `menu_hsync` in 1: menu pipeline hsync.
- `menu_vsync` in 1: menu pipeline vsync.
- `game_rgb` in 12: game pipeline colour.
- `game_hsync` in 1: game pipeline hsync.
- `game_vsync` in 1: game pipeline vsync.
- `cred_rgb` in 12: credits pipeline colour.
- `cred_hsync` in 1: credits pipeline hsync.
- `cred_vsync` in 1: credits pipeline vsync.
- `rgb_out` out 12: registered, muxed colour.
- `hsync_out` out 1: registered, muxed hsync.
- `vsync_out` out 1: registered, muxed vsync.
- `screen` out 2: current state. MENU=0, GAME=1, OVER=2, CREDITS=3.
- `game_rst` out 1: one-cycle pulse on entry to GAME.
- `cred_rst` out 1: one-cycle pulse on entry to CREDITS. It restarts the scroll position.
- `game_freeze` out 1: high while in OVER.

## Operation
- **Edge detection.** `vsync_in`, `mouse_left` and `mouse_right` are each registered once. A rise is defined as `x & ~x_d`, evaluated in the same cycle. `frame` = rise of `vsync_in`.
- **Request latches.** `req_l` and `req_r` are set on a mouse rise and cleared on `frame` or on any state change. If a rise and `frame` fall in the same cycle, the rise is consumed by that frame.
- **Transitions.** Evaluated only in cycles where `frame`=1. Between frames the state is stable.
  - MENU: if `req_l` (or a left rise in this cycle), go to GAME. Otherwise, if `req_r`, go to CREDITS. Left wins when both are set.
  - GAME: if `game_over`=1, go to OVER and clear `cnt`. Mouse requests are ignored.
  - OVER: `cnt`++ every frame. When `cnt` = `OVER_FRAMES`-1, go to MENU. `game_freeze`=1 throughout OVER.
  - CREDITS: if `req_l`, go to MENU. Otherwise `cnt`++, and when `cnt` = `CRED_FRAMES`-1, go to MENU.
  - Entering CREDITS clears `cnt`.
- **Counter.** `cnt` is `CNT_W` wide, never wraps, and is held at 0 in MENU and GAME.
- **Restart pulses.** `game_rst` and `cred_rst` are asserted for exactly the one cycle after the state register takes GAME or CREDITS.
- **Output mux.**
  - MENU selects the menu pipeline.
  - GAME and OVER select the game pipeline.
  - CREDITS selects the credits pipeline.
  - The selected rgb, hsync and vsync are registered together. There is no blanking insertion; each pipeline blanks its own rgb.

## Timing
- **Reset values** (async, `rst`=0): state=MENU, `cnt`=0, `req_l`=`req_r`=0, all edge registers 0, `rgb_out`=0, `hsync_out`=0, `vsync_out`=0, `screen`=0, `game_rst`=0, `cred_rst`=0, `game_freeze`=0.
- **Output latency.** Pipeline inputs to `*_out` take 1 cycle.
- **State change.** A state change occurs at the clock edge that ends the `frame` cycle. `frame` is high one cycle after the raw `vsync_in` rise, so the state changes 2 clocks after the raw rise.
- **Screen switch on outputs.** The first output cycle from the new pipeline is 1 clock after the state change. `screen` and `game_freeze` update together with the state register.
- **Request latency.** Worst case from a mouse rise to a screen change is 1 frame + 3 clocks. A request arriving in OVER is discarded when OVER exits.
- **Reset mid-operation.** Reset in any state returns to MENU immediately. Pending requests are dropped, and no restart pulse is generated on release.
- **Held buttons.** A button held through reset release does not create a rise. A rise requires a 0→1 transition seen after reset.

## Test plan
- **Reset.** Assert `rst`=0 with all inputs toggling → all outputs 0 and `screen`=0. Release `rst`, drive `menu_rgb`=12'hABC → `rgb_out`=12'hABC 1 clock later.
- **Start game.** In MENU, pulse `mouse_left` mid-frame → `screen` stays 0 until the next `vsync_in` rise, then `screen`=1 two clocks after the rise. `game_rst` is high exactly 1 cycle. `rgb_out` follows `game_rgb`.
- **Credits timeout and early exit.** With `CRED_FRAMES`=3, pulse `mouse_right` in MENU → `screen`=3 and one `cred_rst` pulse. After 3 further frames, `screen`=0. Repeat, with a `mouse_left` pulse in frame 1 → `screen`=0 at the next frame.
- **Simultaneous buttons.** `mouse_left` and `mouse_right` rise in the same cycle in MENU → GAME is entered and `cred_rst` never pulses.
- **Game over.** With `OVER_FRAMES`=2, hold `game_over`=1 in GAME → `screen`=2 and `game_freeze`=1 for 2 frames, then `screen`=0. `mouse_left` pulses during OVER cause no transition.
- **Reset during credits.** Assert `rst`=0 in frame 1 of CREDITS → `screen`=0 asynchronously. After release, with no new mouse rise, the block stays in MENU.
